// File: rtl/divider_pkg.sv
// Shared operation codes and FSM state encodings for the divider and multiplier.
package divider_pkg;

  localparam logic [5:0] SigDivu  = 6'b011011;
  localparam logic [5:0] SigMultu = 6'b011001;
  localparam logic [5:0] SigOut   = 6'b111111;
  localparam logic [5:0] SigMflo  = 6'b010010;

  // Count value at which the 32nd iteration is performed.
  localparam logic [5:0] LastIter = 6'd31;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } fsm_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift rem/quot left, compare 33 bits, conditionally subtract.
module div_step (
  input  logic [63:0] rem_quot,
  input  logic [31:0] divisor,
  output logic [63:0] rem_quot_next
);

  logic [32:0] upper;
  logic [31:0] diff;

  always_comb begin
    // Upper 33 bits of the left-shifted register; bit 32 keeps the carry out of the shift.
    upper = rem_quot[63:31];
    // A taken subtract always leaves a result below the divisor, so 32 bits suffice.
    diff  = rem_quot[62:31] - divisor;
    if (upper >= {1'b0, divisor}) begin
      rem_quot_next = {diff, rem_quot[30:0], 1'b1};
    end else begin
      rem_quot_next = {rem_quot[62:0], 1'b0};
    end
  end

endmodule

// File: rtl/divider.sv
// Multi-cycle 32-bit unsigned restoring divider; result is held until copied out by OUT.
module divider
  import divider_pkg::*;
#(
  parameter logic [5:0] DIVU = SigDivu,
  parameter logic [5:0] OUT  = SigOut,
  parameter logic [5:0] MFLO = SigMflo
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] dataA,
  input  logic [31:0] dataB,
  input  logic [5:0]  Signal,
  output logic [63:0] dataOut,
  output logic        busy,
  output logic        divZero
);

  fsm_state_e  state_q, state_d;
  logic [5:0]  count_q, count_d;
  logic [63:0] rq_q, rq_d;
  logic [31:0] divisor_q, divisor_d;
  logic [63:0] out_q, out_d;
  logic        dz_q, dz_d;
  logic [63:0] step_next;

  div_step u_div_step (
    .rem_quot      (rq_q),
    .divisor       (divisor_q),
    .rem_quot_next (step_next)
  );

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    rq_d      = rq_q;
    divisor_d = divisor_q;
    out_d     = out_q;
    dz_d      = dz_q;

    unique case (state_q)
      StIdle: begin
        if (Signal == DIVU) begin
          divisor_d = dataB;
          count_d   = '0;
          if (dataB != 32'd0) begin
            rq_d    = {32'd0, dataA};
            state_d = StRun;
          end else begin
            rq_d    = {dataA, 32'hFFFF_FFFF};
            dz_d    = 1'b1;
            state_d = StDone;
          end
        end
      end
      StRun: begin
        rq_d    = step_next;
        count_d = count_q + 6'd1;
        if (count_q == LastIter) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (Signal == OUT) begin
          out_d = rq_q;
        end else if (Signal == DIVU) begin
          // A new divide replaces the held result without passing through IDLE.
          divisor_d = dataB;
          count_d   = '0;
          if (dataB != 32'd0) begin
            rq_d    = {32'd0, dataA};
            state_d = StRun;
          end else begin
            rq_d    = {dataA, 32'hFFFF_FFFF};
            dz_d    = 1'b1;
            state_d = StDone;
          end
        end else if (Signal == MFLO) begin
          count_d = '0;
          dz_d    = 1'b0;
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      count_q   <= '0;
      rq_q      <= '0;
      divisor_q <= '0;
      out_q     <= '0;
      dz_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      rq_q      <= rq_d;
      divisor_q <= divisor_d;
      out_q     <= out_d;
      dz_q      <= dz_d;
    end
  end

  assign dataOut = out_q;
  assign busy    = (state_q == StRun);
  assign divZero = dz_q;

endmodule

// File: tb/tb_divider.sv
// Directed vector table plus hand sequences for reset, OUT-during-RUN and back-to-back divides.
module tb_divider;
  import divider_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] dataA, dataB;
  logic [5:0]  Signal;
  logic [63:0] dataOut;
  logic        busy, divZero;

  always #5 clk = ~clk;

  divider dut (
    .clk     (clk),
    .reset   (reset),
    .dataA   (dataA),
    .dataB   (dataB),
    .Signal  (Signal),
    .dataOut (dataOut),
    .busy    (busy),
    .divZero (divZero)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
    logic        exp_dz;
  } vec_t;

  localparam int NumVecs = 12;
  vec_t vecs[NumVecs];

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue DIVU, then count cycles with busy high (bounded).
  task automatic run_div(input logic [31:0] a, input logic [31:0] b, output int cycles);
    Signal = SigDivu;
    dataA  = a;
    dataB  = b;
    tick();
    Signal = 6'd0;
    cycles = 0;
    while (busy && cycles < 40) begin
      cycles++;
      tick();
    end
  endtask

  task automatic do_out();
    Signal = SigOut;
    tick();
    Signal = 6'd0;
  endtask

  task automatic do_mflo();
    Signal = SigMflo;
    tick();
    Signal = 6'd0;
  endtask

  initial begin
    int cycles;
    vecs[0]  = '{32'd100,       32'd7,         64'h00000002_0000000E, 1'b0};
    vecs[1]  = '{32'd5,         32'd0,         64'h00000005_FFFFFFFF, 1'b1};
    vecs[2]  = '{32'hFFFFFFFF,  32'd1,         64'h00000000_FFFFFFFF, 1'b0};
    vecs[3]  = '{32'd3,         32'd10,        64'h00000003_00000000, 1'b0};
    vecs[4]  = '{32'd50,        32'd8,         64'h00000002_00000006, 1'b0};
    vecs[5]  = '{32'd9,         32'd2,         64'h00000001_00000004, 1'b0};
    vecs[6]  = '{32'd1000000,   32'd3,         64'h00000001_00051615, 1'b0};
    vecs[7]  = '{32'hFFFFFFFF,  32'hFFFFFFFF,  64'h00000000_00000001, 1'b0};
    vecs[8]  = '{32'h80000000,  32'hFFFFFFFF,  64'h80000000_00000000, 1'b0};
    vecs[9]  = '{32'hDEADBEEF,  32'h10,        64'h0000000F_0DEADBEE, 1'b0};
    vecs[10] = '{32'd0,         32'd0,         64'h00000000_FFFFFFFF, 1'b1};
    vecs[11] = '{32'd0,         32'd5,         64'h00000000_00000000, 1'b0};

    reset  = 1'b0;
    dataA  = '0;
    dataB  = '0;
    Signal = 6'd0;
    #12;
    check("reset_dataOut", dataOut, 64'd0);
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_divZero", {63'd0, divZero}, 64'd0);
    @(negedge clk);
    reset = 1'b1;

    // First DIVU lands on the first edge after release.
    for (int i = 0; i < NumVecs; i++) begin
      run_div(vecs[i].a, vecs[i].b, cycles);
      check($sformatf("v%0d_busy_cycles", i), 64'(cycles), vecs[i].exp_dz ? 64'd0 : 64'd32);
      do_out();
      check($sformatf("v%0d_dataOut", i), dataOut, vecs[i].exp);
      check($sformatf("v%0d_divZero", i), {63'd0, divZero}, {63'd0, vecs[i].exp_dz});
      do_mflo();
      check($sformatf("v%0d_mflo_divZero", i), {63'd0, divZero}, 64'd0);
    end

    // OUT during RUN and operand changes are ignored; DONE holds; DIVU straight from DONE.
    Signal = SigDivu;
    dataA  = 32'd100;
    dataB  = 32'd7;
    tick();
    cycles = 0;
    while (busy && cycles < 40) begin
      Signal = (cycles < 5) ? SigOut : 6'd0;
      dataA  = $urandom;
      dataB  = $urandom;
      cycles++;
      tick();
    end
    Signal = 6'd0;
    check("run_out_ignored", dataOut, 64'h00000000_00000000);
    check("seq_busy_cycles", 64'(cycles), 64'd32);
    repeat (3) tick();
    do_out();
    check("seq_100_7", dataOut, 64'h00000002_0000000E);
    run_div(32'd9, 32'd2, cycles);
    check("done_divu_busy", 64'(cycles), 64'd32);
    do_out();
    check("done_divu_9_2", dataOut, 64'h00000001_00000004);
    do_mflo();
    Signal = SigOut;
    tick();
    Signal = 6'd0;
    check("idle_out_holds", dataOut, 64'h00000001_00000004);

    // Reset mid-RUN: abandon the divide, clear sticky divZero and dataOut.
    run_div(32'd5, 32'd0, cycles);
    check("dz_set", {63'd0, divZero}, 64'd1);
    Signal = SigDivu;
    dataA  = 32'd100;
    dataB  = 32'd7;
    tick();
    Signal = 6'd0;
    repeat (10) tick();
    check("mid_run_busy", {63'd0, busy}, 64'd1);
    reset = 1'b0;
    #1;
    check("async_rst_busy", {63'd0, busy}, 64'd0);
    check("async_rst_dataOut", dataOut, 64'd0);
    check("async_rst_divZero", {63'd0, divZero}, 64'd0);
    repeat (2) tick();
    @(negedge clk);
    reset = 1'b1;
    do_out();
    check("post_rst_out", dataOut, 64'd0);
    check("post_rst_busy", {63'd0, busy}, 64'd0);
    run_div(32'd50, 32'd8, cycles);
    check("post_rst_busy_cycles", 64'(cycles), 64'd32);
    do_out();
    check("post_rst_50_8", dataOut, 64'h00000002_00000006);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
